fir2d_coeff_ctrl: RTL and testbench

Coefficient controller for the 2-D FIR video filter. It accepts per-tap coefficient writes from a host over a valid/ready port into a shadow bank. On a host commit request it arms a swap, and transfers the shadow bank to the active bank on the next vertical-sync leading edge, so a kernel change never lands mid-frame. The active bank drives the filter's flat `coeffs` bus directly.

---
 rtl/fir2d_coeff_if.sv | 27 ++
 rtl/fir2d_coeff_ctrl.sv | 144 ++++++++++++++
 tb/tb_fir2d_coeff_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir2d_coeff_if.sv
// Host-side control port of the 2-D FIR coefficient controller: tap writes,
// commit/abort of a bank swap, and swap/error status.
interface fir2d_coeff_if #(
  parameter int ADDR_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              commit_i;
  logic              abort_i;
  logic              err_clr_i;
  logic              pending_o;
  logic              done_o;
  logic              err_o;
  logic [15:0]       swap_cnt_o;

  modport master (
    output wr_valid, wr_addr, wr_data, commit_i, abort_i, err_clr_i,
    input  wr_ready, pending_o, done_o, err_o, swap_cnt_o
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit_i, abort_i, err_clr_i,
    output wr_ready, pending_o, done_o, err_o, swap_cnt_o
  );
endinterface

// File: rtl/fir2d_coeff_ctrl.sv
// Double-buffered coefficient bank for the 2-D FIR: host writes a shadow bank,
// a commit arms a swap into the active bank at the next vsync leading edge.
// Optional feature macro FIR2D_CTRL_READBACK_EN adds a registered tap readback port.
module fir2d_coeff_ctrl #(
  parameter int W_H    = 5,
  parameter int W_L    = 5,
  parameter int ADDR_W = 8,
  parameter int VS_POL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir2d_coeff_if.slave             host,
  input  logic                     vs_i,
`ifdef FIR2D_CTRL_READBACK_EN
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_sel,
  output logic [15:0]              rd_data,
`endif
  output logic [W_H*W_L*16-1:0]    coeffs
);

  localparam int N      = W_H * W_L;
  localparam int ID_TAP = (W_H / 2) * W_L + W_L / 2;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] shadow_q [N];
  logic [15:0] shadow_d [N];
  logic [15:0] active_q [N];
  logic [15:0] active_d [N];
  logic [15:0] swap_cnt_q, swap_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        vs_act_q, vs_act_d;

  logic             vs_rise;
  logic             wr_fire;
  logic             wr_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic             err_set;

  // History holds "vsync was active", so polarity is folded in once here.
  assign vs_act_d    = (VS_POL != 0) ? vs_i : ~vs_i;
  assign vs_rise     = vs_act_d & ~vs_act_q;
  assign wr_fire     = host.wr_valid & (state_q == IDLE);
  assign wr_in_range = ({1'b0, host.wr_addr} < (ADDR_W + 1)'(N));
  assign wr_idx      = host.wr_addr[IDX_W-1:0];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    state_d    = state_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    swap_cnt_d = swap_cnt_q;
    done_d     = 1'b0;
    err_set    = 1'b0;

    // Writes are only accepted in IDLE, so a swap always copies a settled shadow.
    if (wr_fire) begin
      if (wr_in_range) shadow_d[wr_idx] = host.wr_data;
      else             err_set          = 1'b1;
    end

    err_d = err_set | (err_q & ~host.err_clr_i);

    unique case (state_q)
      IDLE: begin
        if (host.commit_i) state_d = ARMED;
      end
      ARMED: begin
        if (host.abort_i) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          active_d   = shadow_q;
          swap_cnt_d = swap_cnt_q + 16'd1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      swap_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vs_act_q   <= 1'b0;
      // NOTE: both banks are reset because the filter must see a valid identity kernel out of reset.
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= (i == ID_TAP) ? 16'h0100 : 16'h0000;
        active_q[i] <= (i == ID_TAP) ? 16'h0100 : 16'h0000;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q    <= state_d;
      swap_cnt_q <= swap_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vs_act_q   <= vs_act_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) coeffs[16*i +: 16] = active_q[i];
  end

  assign host.wr_ready   = (state_q == IDLE);
  assign host.pending_o  = (state_q == ARMED);
  assign host.done_o     = done_q;
  assign host.err_o      = err_q;
  assign host.swap_cnt_o = swap_cnt_q;

`ifdef FIR2D_CTRL_READBACK_EN
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;

  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(N));
  assign rd_idx      = rd_addr[IDX_W-1:0];

  always_comb begin
    rd_data_d = 16'h0000;
    if (rd_in_range) rd_data_d = rd_sel ? active_q[rd_idx] : shadow_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= 16'h0000;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fir2d_coeff_ctrl.sv
// Directed bench for fir2d_coeff_ctrl (5x5 kernel): committed banks are queued
// as expected swaps and checked when done_o reports the swap.
module tb_fir2d_coeff_ctrl;

  localparam int N  = 25;
  localparam int BW = N * 16;

  typedef struct {
    logic [BW-1:0] coeffs;
    logic [15:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic vs_i;
  logic [BW-1:0] coeffs;
`ifdef FIR2D_CTRL_READBACK_EN
  logic [7:0]  rd_addr;
  logic        rd_sel;
  logic [15:0] rd_data;
`endif

  fir2d_coeff_if #(.ADDR_W(8)) host ();

  fir2d_coeff_ctrl #(.W_H(5), .W_L(5), .ADDR_W(8), .VS_POL(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (host),
    .vs_i    (vs_i),
`ifdef FIR2D_CTRL_READBACK_EN
    .rd_addr (rd_addr),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
`endif
    .coeffs  (coeffs)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  exp_t          sb[$];
  logic [15:0]   sh_m [N];
  logic [BW-1:0] act_m;
  logic [15:0]   cnt_m;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] shadow_flat();
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = sh_m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) sh_m[i] = (i == 12) ? 16'h0100 : 16'h0000;
    act_m = shadow_flat();
    cnt_m = 16'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    host.wr_valid = 1'b1;
    host.wr_addr  = a;
    host.wr_data  = d;
    tick();
    host.wr_valid = 1'b0;
    if (a < 8'(N)) sh_m[a] = d;
  endtask

  task automatic push_commit();
    exp_t e;
    e.coeffs = shadow_flat();
    e.cnt    = cnt_m + 16'd1;
    sb.push_back(e);
  endtask

  // Every done_o pulse must match the oldest committed bank still outstanding.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && host.done_o === 1'b1) begin
      check("sb_nonempty", BW'(sb.size() != 0), BW'(1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_coeffs", coeffs, e.coeffs);
        check("sb_swap_cnt", BW'(host.swap_cnt_o), BW'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    vs_i           = 1'b0;
    host.wr_valid  = 1'b0;
    host.wr_addr   = '0;
    host.wr_data   = '0;
    host.commit_i  = 1'b0;
    host.abort_i   = 1'b0;
    host.err_clr_i = 1'b0;
`ifdef FIR2D_CTRL_READBACK_EN
    rd_addr = '0;
    rd_sel  = 1'b0;
`endif
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_coeffs", coeffs, act_m);
    check("rst_wr_ready", BW'(host.wr_ready), BW'(1));
    check("rst_swap_cnt", BW'(host.swap_cnt_o), BW'(0));
    check("rst_pending", BW'(host.pending_o), BW'(0));
    check("rst_done", BW'(host.done_o), BW'(0));
    check("rst_err", BW'(host.err_o), BW'(0));

    // Load all taps with n*3, commit, vsync edge 10 cycles later
    for (int n = 0; n < N; n++) do_write(8'(n), 16'(n * 3));
    check("load_no_leak", coeffs, act_m);
    host.commit_i = 1'b1;
    tick();
    host.commit_i = 1'b0;
    push_commit();
    check("arm_pending", BW'(host.pending_o), BW'(1));
    check("arm_wr_ready", BW'(host.wr_ready), BW'(0));
    // A write offered while armed must be ignored
    host.wr_valid = 1'b1; host.wr_addr = 8'd0; host.wr_data = 16'h7777;
    for (int c = 0; c < 10; c++) begin
      tick();
      host.wr_valid = 1'b0;
      check("armed_hold_coeffs", coeffs, act_m);
    end
    check("armed_hold_pending", BW'(host.pending_o), BW'(1));
    vs_i = 1'b1;
    tick();
    act_m = shadow_flat();
    cnt_m = cnt_m + 16'd1;
    check("swap1_coeffs", coeffs, act_m);
    check("swap1_done", BW'(host.done_o), BW'(1));
    check("swap1_pending", BW'(host.pending_o), BW'(0));
    check("swap1_cnt", BW'(host.swap_cnt_o), BW'(cnt_m));
    tick();
    check("swap1_done_once", BW'(host.done_o), BW'(0));

    // Abort coinciding with a vsync edge, then a 1-cycle commit-to-swap
    vs_i = 1'b0;
    do_write(8'd0, 16'h0200);
    host.commit_i = 1'b1;
    tick();
    host.commit_i = 1'b0;
    push_commit();
    host.abort_i = 1'b1;
    vs_i = 1'b1;
    tick();
    host.abort_i = 1'b0;
    void'(sb.pop_back());
    check("abort_pending", BW'(host.pending_o), BW'(0));
    check("abort_cnt", BW'(host.swap_cnt_o), BW'(cnt_m));
    check("abort_coeffs", coeffs, act_m);
    check("abort_done", BW'(host.done_o), BW'(0));
    vs_i = 1'b0;
    host.abort_i = 1'b1;   // abort while idle: ignored
    tick();
    host.abort_i = 1'b0;
    host.commit_i = 1'b1;
    tick();
    host.commit_i = 1'b0;
    push_commit();
    vs_i = 1'b1;
    tick();
    act_m = shadow_flat();
    cnt_m = cnt_m + 16'd1;
    check("swap2_coeffs", coeffs, act_m);
    check("swap2_cnt", BW'(host.swap_cnt_o), BW'(cnt_m));
    check("swap2_done", BW'(host.done_o), BW'(1));

    // Out-of-range writes and sticky error
    do_write(8'd25, 16'h1234);
    check("err_set", BW'(host.err_o), BW'(1));
    host.err_clr_i = 1'b1;
    do_write(8'd30, 16'h5678);
    host.err_clr_i = 1'b0;
    check("err_set_wins", BW'(host.err_o), BW'(1));
    host.err_clr_i = 1'b1;
    tick();
    host.err_clr_i = 1'b0;
    check("err_cleared", BW'(host.err_o), BW'(0));

    // vsync held high through commit; write in the commit cycle is included
    vs_i = 1'b1;
    tick();
    check("idle_edge_no_swap", coeffs, act_m);
    host.wr_valid = 1'b1; host.wr_addr = 8'd1; host.wr_data = 16'h0011;
    host.commit_i = 1'b1;
    tick();
    host.wr_valid = 1'b0;
    host.commit_i = 1'b0;
    sh_m[1] = 16'h0011;
    push_commit();
    host.commit_i = 1'b1;  // commit while armed: ignored
    tick();
    host.commit_i = 1'b0;
    check("held_vs_no_swap", coeffs, act_m);
    check("held_vs_pending", BW'(host.pending_o), BW'(1));
    vs_i = 1'b0;
    tick();
    check("vs_low_no_swap", coeffs, act_m);
    vs_i = 1'b1;
    tick();
    act_m = shadow_flat();
    cnt_m = cnt_m + 16'd1;
    check("reraise_coeffs", coeffs, act_m);
    check("reraise_cnt", BW'(host.swap_cnt_o), BW'(cnt_m));

    // Asynchronous reset while armed
    vs_i = 1'b0;
    do_write(8'd12, 16'h0005);
    host.commit_i = 1'b1;
    tick();
    host.commit_i = 1'b0;
    push_commit();
    check("pre_rst_pending", BW'(host.pending_o), BW'(1));
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    model_reset();
    check("async_rst_coeffs", coeffs, act_m);
    check("async_rst_pending", BW'(host.pending_o), BW'(0));
    check("async_rst_cnt", BW'(host.swap_cnt_o), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef FIR2D_CTRL_READBACK_EN
    do_write(8'd7, 16'hFF80);
    rd_addr = 8'd7;
    rd_sel  = 1'b0;
    tick();
    check("rd_shadow", BW'(rd_data), BW'(16'hFF80));
    rd_sel = 1'b1;
    tick();
    check("rd_active", BW'(rd_data), BW'(16'h0000));
    rd_addr = 8'd40;
    rd_sel  = 1'b0;
    tick();
    check("rd_out_of_range", BW'(rd_data), BW'(16'h0000));
`endif

    check("sb_drained", BW'(sb.size()), BW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
